// File: rtl/pipelined_addsub.sv
// Segmented carry-lookahead adder/subtractor, one SEG-bit slice per stage.
// Valid/ready handshake with a single global stall.
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;
  localparam int GRP    = SEG / 4;

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ovf;
    logic             zero;
  } beat_t;

  function automatic logic [4:0] cla4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  function automatic logic [SEG:0] seg_add(
    input logic [SEG-1:0] x,
    input logic [SEG-1:0] y,
    input logic           ci
  );
    logic [SEG:0] o;
    logic         c;
    logic [4:0]   t;
    o = '0;
    c = ci;
    for (int g = 0; g < GRP; g++) begin
      t          = cla4(x[g*4 +: 4], y[g*4 +: 4], c);
      o[g*4 +: 4] = t[3:0];
      c          = t[4];
    end
    o[SEG] = c;
    return o;
  endfunction

  beat_t        pipe [STAGES+1];
  beat_t        nxt  [STAGES];
  logic [SEG:0] r    [STAGES];
  logic         advance;

  assign advance  = !pipe[STAGES].v || out_ready;
  assign in_ready = advance;

  // Per-stage slice add; the last stage also derives the flags.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt[k] = pipe[k];
      r[k]   = seg_add(pipe[k].a[k*SEG +: SEG],
                       pipe[k].b[k*SEG +: SEG],
                       pipe[k].c);
      nxt[k].s[k*SEG +: SEG] = r[k][SEG-1:0];
      nxt[k].c    = r[k][SEG];
      nxt[k].ovf  = 1'b0;
      nxt[k].zero = 1'b0;
      if (k == STAGES - 1) begin
        nxt[k].ovf  = r[k][SEG] ^ (pipe[k].a[WIDTH-1]
                    ^ pipe[k].b[WIDTH-1] ^ r[k][SEG-1]);
        nxt[k].zero = ~|nxt[k].s;
      end
    end
  end

  // Capture effective operands, then shift all stages on advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) pipe[k] <= '0;
    end else if (advance) begin
      pipe[0].v    <= in_valid;
      pipe[0].a    <= a;
      pipe[0].b    <= op_sub ? ~b : b;
      pipe[0].s    <= '0;
      pipe[0].c    <= op_sub | cin;
      pipe[0].ovf  <= 1'b0;
      pipe[0].zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) pipe[k+1] <= nxt[k];
    end
  end

  assign out_valid = pipe[STAGES].v;
  assign sum       = pipe[STAGES].s;
  assign cout      = pipe[STAGES].c;
  assign ovf       = pipe[STAGES].ovf;
  assign zero      = pipe[STAGES].zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, streaming
// backpressure, mid-flight reset and a random sweep on two sizes.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, cin, op_sub, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] sum;
  logic        in_ready2, out_valid2, cout2, ovf2, zero2;
  logic [15:0] sum2;

  int total = 0;
  int bad   = 0;
  res_t q32[$];
  res_t q16[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(32), .SEG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipelined_addsub #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready2),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid2), .out_ready(out_ready),
    .sum(sum2), .cout(cout2), .ovf(ovf2), .zero(zero2)
  );

  function automatic res_t model(
    input int          n,
    input logic [31:0] x,
    input logic [31:0] y,
    input logic        ci,
    input logic        sub
  );
    logic [31:0] m, yy;
    logic [32:0] f;
    res_t        rr;
    m     = (n == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    yy    = (sub ? ~y : y) & m;
    f     = {1'b0, x & m} + {1'b0, yy} + {32'b0, sub | ci};
    rr.s  = f[31:0] & m;
    rr.c  = f[n];
    rr.o  = (x[n-1] == yy[n-1]) && (rr.s[n-1] != x[n-1]);
    rr.z  = (rr.s == 32'h0);
    return rr;
  endfunction

  task automatic test_reset;
    in_valid = 0; a = 0; b = 0; cin = 0; op_sub = 0;
    out_ready = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, sum, cout, ovf, zero, in_ready} !==
        {1'b0, 32'h0, 3'b000, 1'b1}) begin
      bad++;
      $display("FAIL reset32 got=%h want=%h",
               {out_valid, sum, cout, ovf, zero, in_ready},
               {1'b0, 32'h0, 3'b000, 1'b1});
    end
    total++;
    if ({out_valid2, sum2, cout2, ovf2, zero2, in_ready2} !==
        {1'b0, 16'h0, 3'b000, 1'b1}) begin
      bad++;
      $display("FAIL reset16 got=%h want=%h",
               {out_valid2, sum2, cout2, ovf2, zero2, in_ready2},
               {1'b0, 16'h0, 3'b000, 1'b1});
    end
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
  endtask

  task automatic run_one(
    input logic [31:0] ta, input logic [31:0] tb,
    input logic tc, input logic ts,
    input logic [31:0] es, input logic ec,
    input logic eo, input logic ez, input string nm
  );
    int lat;
    @(negedge clk);
    a = ta; b = tb; cin = tc; op_sub = ts;
    in_valid = 1; out_ready = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    total++;
    if (lat != 4 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_latency got=%0d want=4", nm, lat);
    end
    total++;
    if ({sum, cout, ovf, zero} !== {es, ec, eo, ez}) begin
      bad++;
      $display("FAIL %s got=%h/%b%b%b want=%h/%b%b%b", nm,
               sum, cout, ovf, zero, es, ec, eo, ez);
    end
  endtask

  task automatic test_directed;
    run_one(32'hFFFF_FFFF, 32'h1, 0, 0, 32'h0, 1, 0, 1, "add_wrap");
    run_one(32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1, 0, "add_ovf");
    run_one(32'h0000_00FF, 32'h0, 1, 0, 32'h0000_0100, 0, 0, 0, "add_cin");
    run_one(32'h5, 32'h7, 1, 1, 32'hFFFF_FFFE, 0, 0, 0, "sub_neg_c1");
    run_one(32'h5, 32'h7, 0, 1, 32'hFFFF_FFFE, 0, 0, 0, "sub_neg_c0");
    run_one(32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1, 0, "sub_ovf");
  endtask

  task automatic test_stream;
    logic [7:0]  pat;
    logic [34:0] prev;
    logic        hold;
    int nxt, got, cyc, ibad, sbad;
    res_t e;
    pat = 8'b1101_0011;
    nxt = 1; got = 0; cyc = 0; ibad = 0; sbad = 0;
    hold = 0; prev = '0;
    q32.delete();
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      out_ready = pat[cyc % 8];
      in_valid  = (nxt <= 8);
      a = 32'(nxt); b = 32'(nxt); cin = 0; op_sub = 0;
      #1;
      if (hold && {sum, cout, ovf, zero} !== prev) sbad++;
      if (in_ready !== !(out_valid && !out_ready)) ibad++;
      if (in_valid && in_ready) begin
        e.s = 32'(2 * nxt); e.c = 0; e.o = 0; e.z = 0;
        q32.push_back(e);
        nxt++;
      end
      if (out_valid && out_ready) begin
        got++;
        total++;
        if (q32.size() == 0) begin
          bad++;
          $display("FAIL stream_extra got=%h want=none", sum);
        end else begin
          e = q32.pop_front();
          if ({sum, cout, ovf, zero} !== {e.s, e.c, e.o, e.z}) begin
            bad++;
            $display("FAIL stream_result got=%h want=%h", sum, e.s);
          end
        end
      end
      hold = out_valid && !out_ready;
      prev = {sum, cout, ovf, zero};
      cyc++;
    end
    in_valid = 0;
    total++;
    if (sbad != 0) begin
      bad++;
      $display("FAIL stream_stable got=%0d want=0", sbad);
    end
    total++;
    if (ibad != 0) begin
      bad++;
      $display("FAIL stream_in_ready got=%0d want=0", ibad);
    end
    total++;
    if (got != 8 || q32.size() != 0) begin
      bad++;
      $display("FAIL stream_count got=%0d left=%0d want=8/0",
               got, q32.size());
    end
    out_ready = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int vbad;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'(i + 100); b = 32'(i); cin = 0; op_sub = 0;
      in_valid = 1; out_ready = 1;
    end
    @(negedge clk);
    in_valid = 0;
    rst_n = 0;
    #1;
    total++;
    if ({out_valid, sum, cout, ovf, zero} !== {1'b0, 32'h0, 3'b000}) begin
      bad++;
      $display("FAIL midreset_values got=%h want=0",
               {out_valid, sum, cout, ovf, zero});
    end
    @(negedge clk);
    rst_n = 1;
    vbad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || out_valid2 !== 1'b0) vbad++;
    end
    total++;
    if (vbad != 0) begin
      bad++;
      $display("FAIL midreset_stale got=%0d want=0", vbad);
    end
    run_one(32'd10, 32'd3, 0, 1, 32'd7, 1, 0, 0, "post_reset_sub");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random;
    int acc, cyc;
    res_t e;
    acc = 0; cyc = 0;
    q32.delete();
    q16.delete();
    while ((acc < 10000 || q32.size() != 0 || q16.size() != 0)
           && cyc < 60000) begin
      @(negedge clk);
      in_valid  = (acc < 10000) && ($urandom_range(9) != 0);
      a         = $urandom;
      b         = $urandom;
      cin       = 1'($urandom_range(1));
      op_sub    = 1'($urandom_range(1));
      out_ready = (acc >= 10000) || ($urandom_range(3) != 0);
      #1;
      if (in_valid && in_ready) begin
        q32.push_back(model(32, a, b, cin, op_sub));
        acc++;
      end
      if (in_valid && in_ready2)
        q16.push_back(model(16, a, b, cin, op_sub));
      if (out_valid && out_ready) begin
        total++;
        if (q32.size() == 0) begin
          bad++;
          $display("FAIL rand32_extra got=%h want=none", sum);
        end else begin
          e = q32.pop_front();
          if ({sum, cout, ovf, zero} !== {e.s, e.c, e.o, e.z}) begin
            bad++;
            $display("FAIL rand32 got=%h/%b%b%b want=%h/%b%b%b",
                     sum, cout, ovf, zero, e.s, e.c, e.o, e.z);
          end
        end
      end
      if (out_valid2 && out_ready) begin
        total++;
        if (q16.size() == 0) begin
          bad++;
          $display("FAIL rand16_extra got=%h want=none", sum2);
        end else begin
          e = q16.pop_front();
          if ({sum2, cout2, ovf2, zero2} !==
              {e.s[15:0], e.c, e.o, e.z}) begin
            bad++;
            $display("FAIL rand16 got=%h/%b%b%b want=%h/%b%b%b",
                     sum2, cout2, ovf2, zero2, e.s[15:0], e.c, e.o, e.z);
          end
        end
      end
      cyc++;
    end
    in_valid = 0;
    total++;
    if (acc != 10000 || q32.size() != 0 || q16.size() != 0) begin
      bad++;
      $display("FAIL rand_drain got=%0d/%0d/%0d want=10000/0/0",
               acc, q32.size(), q16.size());
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_stream;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
